bin_mult_ctrl: RTL and testbench

- Upstream sequencer for bin_mult. It loads the 7 weight rows into the multiplier's shift register and latches one 7x7 binary image window per handshake.
- It issues the clear and accumulate opcode sequence over rows 0..6, captures the finished popcount sum, and thresholds it to one binary activation.
- Output leaves on a valid/ready stream to the next layer.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/bin_mult_ctrl.sv | 96 +++++++++
 tb/tb_bin_mult_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and constants for the bin_mult sequencer (bin_mult_ctrl)
package bnn_pkg;
   typedef enum logic [2:0] {S_LOADW, S_WAIT, S_CLR, S_ACC, S_DRAIN, S_OUT} state_t;
   localparam int ROWS  = 7;
   localparam int ROW_W = 7;
   localparam int ACC_W = 7;
   localparam int OP_CLR_BIT = 0;
   localparam int OP_SEL_LSB = 1;
   localparam int OP_ADD_BIT = 4;
   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_CLR = 5'b00001;
   function automatic logic [4:0] acc_op(input logic [2:0] row);
      acc_op = OP_NOP;
      acc_op[OP_ADD_BIT] = 1'b1;
      acc_op[OP_SEL_LSB +: 3] = row;
   endfunction
endpackage

// File: rtl/bin_mult_ctrl.sv
// bin_mult_ctrl: loads weights into bin_mult, sequences one window through it, thresholds the popcount sum
// Ports: clk/rst (sync, active-low); wt_* weight-row stream (row 6 first); win_* 49-bit window stream;
// thresh signed threshold; mult_* drive/observe bin_mult; out_* valid/ready result (bit + signed sum).
// Optional: BIN_MULT_CTRL_PERF_EN adds win_count, a wrapping count of completed output handshakes.
module bin_mult_ctrl import bnn_pkg::*; (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wt_valid,
   output logic                    wt_ready,
   input  logic [ROW_W-1:0]        wt_row,
   input  logic                    win_valid,
   output logic                    win_ready,
   input  logic [ROWS*ROW_W-1:0]   win_img,
   input  logic [ACC_W-1:0]        thresh,
   output logic                    mult_w_en,
   output logic [ROW_W-1:0]        mult_w_input,
   output logic [ROWS*ROW_W-1:0]   mult_img,
   output logic [4:0]              mult_opcode,
   input  logic [ACC_W-1:0]        mult_popcnt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_bit,
   output logic [ACC_W-1:0]        out_sum
`ifdef BIN_MULT_CTRL_PERF_EN
   ,
   output logic [15:0]             win_count
`endif
);
   localparam logic [2:0] LAST = 3'(ROWS - 1);
   state_t                  r_state, w_next;
   logic [2:0]              r_row, w_row_nx;
   logic [ROWS*ROW_W-1:0]   r_img;
   logic [ACC_W-1:0]        r_sum;
   logic                    r_bit;
   logic                    w_wt_acc;
   // rst gates the beat so a weight offered during reset never reaches bin_mult
   assign wt_ready     = r_state == S_LOADW;
   assign win_ready    = r_state == S_WAIT;
   assign out_valid    = r_state == S_OUT;
   assign w_wt_acc     = wt_valid & wt_ready & rst;
   assign mult_w_en    = w_wt_acc;
   assign mult_w_input = w_wt_acc ? wt_row : '0;
   assign mult_img     = r_img;
   assign mult_opcode  = r_state == S_CLR ? OP_CLR : r_state == S_ACC ? acc_op(r_row) : OP_NOP;
   assign out_sum      = r_sum;
   assign out_bit      = r_bit;
   always_comb begin
      w_next   = r_state;
      w_row_nx = r_row;
      case (r_state)
         S_LOADW: if (w_wt_acc) begin
            w_row_nx = r_row == LAST ? 3'd0 : r_row + 3'd1;
            w_next   = r_row == LAST ? S_WAIT : S_LOADW;
         end
         // a waiting window wins; a lone weight beat only reopens loading
         S_WAIT:  w_next = win_valid ? S_CLR : wt_valid ? S_LOADW : S_WAIT;
         S_CLR: begin
            w_next   = S_ACC;
            w_row_nx = 3'd0;
         end
         S_ACC: begin
            w_row_nx = r_row == LAST ? 3'd0 : r_row + 3'd1;
            w_next   = r_row == LAST ? S_DRAIN : S_ACC;
         end
         S_DRAIN: w_next = S_OUT;
         S_OUT:   w_next = out_ready ? S_WAIT : S_OUT;
         default: w_next = S_LOADW;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_LOADW;
         r_row   <= 3'd0;
         r_img   <= '0;
         r_sum   <= '0;
         r_bit   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_row   <= w_row_nx;
         if (win_valid && win_ready) r_img <= win_img;
         // bin_mult's registered sum settles one cycle after the last add
         if (r_state == S_DRAIN) begin
            r_sum <= mult_popcnt;
            r_bit <= $signed(mult_popcnt) >= $signed(thresh);
         end
      end
   end
`ifdef BIN_MULT_CTRL_PERF_EN
   logic [15:0] r_cnt;
   assign win_count = r_cnt;
   always_ff @(posedge clk) begin
      if (!rst) r_cnt <= '0;
      else if (out_valid && out_ready) r_cnt <= r_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_bin_mult_ctrl.sv
// tb_bin_mult_ctrl: randomized self-checking bench with a behavioural bin_mult and a window-level reference model
module tb_bin_mult_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wt_valid = 1'b0, win_valid = 1'b0, out_ready = 1'b0;
   logic [6:0]  wt_row = '0, thresh = '0;
   logic [48:0] win_img = '0;
   logic        wt_ready, win_ready, mult_w_en, out_valid, out_bit;
   logic [6:0]  mult_w_input, mult_popcnt, out_sum;
   logic [48:0] mult_img;
   logic [4:0]  mult_opcode;
`ifdef BIN_MULT_CTRL_PERF_EN
   logic [15:0] win_count;
`endif
   int n_vec = 0, n_err = 0, pulses = 0;
   logic [4:0] ops [9];
   always #5 clk = ~clk;
   bin_mult_ctrl dut (
`ifdef BIN_MULT_CTRL_PERF_EN
      .win_count(win_count),
`endif
      .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
      .win_valid(win_valid), .win_ready(win_ready), .win_img(win_img), .thresh(thresh),
      .mult_w_en(mult_w_en), .mult_w_input(mult_w_input), .mult_img(mult_img),
      .mult_opcode(mult_opcode), .mult_popcnt(mult_popcnt), .out_valid(out_valid),
      .out_ready(out_ready), .out_bit(out_bit), .out_sum(out_sum));
   // behavioural bin_mult: shift register of weight rows, each row contributes popcount of its low 6 AND bits
   logic [6:0] bw [7];
   logic [6:0] acc;
   assign mult_popcnt = acc;
   always @(posedge clk) begin
      if (mult_w_en) begin
         for (int k = 6; k > 0; k--) bw[k] <= bw[k-1];
         bw[0] <= mult_w_input;
      end
      if (!rst || mult_opcode[0]) acc <= '0;
      else if (mult_opcode[4])
         acc <= acc + 7'($countones(bw[mult_opcode[3:1]][5:0] & mult_img[7*mult_opcode[3:1] +: 6]));
   end
   // reference model: phase 0 load, 1 wait, 2 busy (m_t cycles since accept), 3 output
   int          m_ph = 0, m_t = 0, m_nb = 0;
   bit          started = 0;
   logic [6:0]  m_beat [7];
   logic [48:0] m_img = '0;
   logic [6:0]  m_sum = '0;
   logic        m_bit = 1'b0;
   function automatic int ref_sum();
      int s = 0;
      for (int k = 0; k < 7; k++) s += $countones(m_beat[6-k][5:0] & m_img[7*k +: 6]);
      return s;
   endfunction
   always @(posedge clk) begin
      int s;
      logic signed [6:0] ts;
      if (!rst) begin
         started = 1; m_ph = 0; m_nb = 0; m_img = '0; m_sum = '0; m_bit = 1'b0;
      end else if (m_ph == 0) begin
         if (wt_valid) begin
            m_beat[m_nb] = wt_row;
            m_nb++;
            if (m_nb == 7) begin m_nb = 0; m_ph = 1; end
         end
      end else if (m_ph == 1) begin
         if (win_valid) begin m_img = win_img; m_ph = 2; m_t = 0; end
         else if (wt_valid) m_ph = 0;
      end else if (m_ph == 2) begin
         if (m_t == 8) begin
            s = ref_sum();
            ts = thresh;
            m_sum = 7'(s);
            m_bit = s >= int'(ts);
            m_ph = 3;
         end else m_t++;
      end else if (out_ready) m_ph = 1;
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) if (started) begin
      logic [4:0] e_op;
      e_op = m_ph != 2 || m_t == 8 ? 5'h00 : m_t == 0 ? 5'h01 : 5'(16 + 2 * (m_t - 1));
      chk("wt_ready", wt_ready, m_ph == 0);
      chk("win_ready", win_ready, m_ph == 1);
      chk("out_valid", out_valid, m_ph == 3);
      chk("opcode", mult_opcode, e_op);
      chk("w_en", mult_w_en, m_ph == 0 && wt_valid && rst);
      if (m_ph == 0 && wt_valid && rst) chk("w_input", mult_w_input, wt_row);
      chk("mult_img", mult_img, m_img);
      chk("out_sum", out_sum, m_sum);
      chk("out_bit", out_bit, m_bit);
      if (mult_w_en) pulses++;
   end
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic load_w(input logic [6:0] r [7], input int gmax);
      for (int i = 0; i < 7; i++) begin
         bit ok = 0;
         wt_row = r[i];
         wt_valid = 1'b1;
         for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = wt_ready;
         end
         chk("wt_accept_timeout", ok, 1);
         tick();
         wt_valid = 1'b0;
         repeat ($urandom_range(gmax)) tick();
      end
   endtask
   task automatic send_win(input logic [48:0] img, input logic [6:0] th);
      bit ok = 0;
      win_img = img;
      thresh = th;
      win_valid = 1'b1;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         ok = win_ready;
      end
      chk("win_accept_timeout", ok, 1);
      tick();
      win_valid = 1'b0;
   endtask
   task automatic wait_out();
      int lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (k <= 9) ops[k-1] = mult_opcode;
         if (out_valid) lat = k;
      end
      chk("latency", lat, 10);
   endtask
   task automatic take_out(input int stall);
      out_ready = 1'b0;
      repeat (stall) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask
   logic [6:0]  w_ones [7], w_ramp [7], w_rnd [7];
   logic [48:0] img20;
   logic [4:0]  op_exp [9];
   initial begin
      int p0;
      bit found;
      w_ones = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      w_ramp = '{7'h7F, 7'h3F, 7'h1F, 7'h0F, 7'h07, 7'h03, 7'h01};
      op_exp = '{5'h01, 5'h10, 5'h12, 5'h14, 5'h16, 5'h18, 5'h1A, 5'h1C, 5'h00};
      img20 = '0;
      img20[6:0] = 7'h3F; img20[13:7] = 7'h3F; img20[20:14] = 7'h3F; img20[27:21] = 7'h03;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wt_ready", wt_ready, 1);
      chk("rst_win_ready", win_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_opcode", mult_opcode, 0);
      chk("rst_w_en", mult_w_en, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      p0 = pulses;
      load_w(w_ramp, 2);
      @(negedge clk);
      chk("w_pulses", pulses - p0, 7);
      chk("loaded_win_ready", win_ready, 1);
      chk("loaded_wt_ready", wt_ready, 0);
      tick();
      load_w(w_ones, 1);
      send_win('1, 7'd21);
      wait_out();
      for (int i = 0; i < 9; i++) chk($sformatf("op_seq%0d", i), ops[i], op_exp[i]);
      chk("ones_sum", out_sum, 42);
      chk("ones_bit", out_bit, 1);
      #1;
      win_img = '0; thresh = 7'h78; win_valid = 1'b1; out_ready = 1'b0;
      repeat (5) begin
         tick();
         @(negedge clk);
         chk("stall_sum", out_sum, 42);
         chk("stall_bit", out_bit, 1);
         chk("stall_win_ready", win_ready, 0);
      end
      #1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      chk("post_hs_win_ready", win_ready, 1);
      tick();
      win_valid = 1'b0;
      wait_out();
      chk("zero_sum", out_sum, 0);
      chk("neg_thresh_bit", out_bit, 1);
      take_out(0);
      send_win(img20, 7'd20);
      wait_out();
      chk("eq_sum", out_sum, 20);
      chk("eq_bit", out_bit, 1);
      take_out(1);
      send_win(img20, 7'd21);
      wait_out();
      chk("gt_bit", out_bit, 0);
      take_out(0);
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(3) == 0) begin
            foreach (w_rnd[i]) w_rnd[i] = 7'($urandom);
            wt_valid = 1'b1;
            load_w(w_rnd, 2);
         end
         send_win(49'({$urandom, $urandom}), 7'($urandom));
         wait_out();
         take_out($urandom_range(3));
      end
      load_w(w_ones, 0);
      send_win('1, 7'd42);
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         found = mult_opcode == 5'h16;
      end
      chk("row3_reached", found, 1);
      #1;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("abort_wt_ready", wt_ready, 1);
      chk("abort_opcode", mult_opcode, 0);
      chk("abort_out_valid", out_valid, 0);
      tick();
      load_w(w_ones, 1);
      send_win('1, 7'd42);
      wait_out();
      chk("after_abort_sum", out_sum, 42);
      chk("after_abort_bit", out_bit, 1);
      take_out(0);
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
